// File: rtl/counter_monitor.sv
// Sequence monitor for an upstream counter: tracks start/count/saturate/restart
// behaviour of Data_i and queues one event per transition in a small FWFT FIFO.
module counter_monitor #(
  parameter int unsigned Init  = 8,
  parameter int unsigned Limit = 64,
  parameter int unsigned Depth = 4
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic [31:0] Data_i,
  input  logic        Event_ready_i,
  output logic        Event_valid_o,
  output logic [1:0]  Event_code_o,
  output logic [31:0] Event_data_o,
  output logic [1:0]  State_o,
  output logic        Error_o,
  output logic        Overflow_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [31:0] InitV     = 32'(Init);
  localparam logic [31:0] InitNextV = 32'(Init) + 32'd1;
  localparam logic [31:0] LimitV    = 32'(Limit);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SAT   = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EV_START   = 2'd0,
    EV_SAT     = 2'd1,
    EV_ERROR   = 2'd2,
    EV_RESTART = 2'd3
  } code_e;

  state_e      state_q, state_d;
  logic [31:0] prev_q;
  logic        error_q, error_d;
  logic        overflow_q, overflow_d;

  logic        push_req;
  code_e       push_code;
  logic [31:0] expected;

  logic [1:0]      mem_code_q [Depth];
  logic [31:0]     mem_data_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            fifo_full, fifo_empty;
  logic            do_push, do_pop;

  assign expected = prev_q + 32'd1;

  // ---------------------------------------------------------------------------
  // Monitor FSM: next state, event request and sticky error.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    push_req  = 1'b0;
    push_code = EV_START;
    unique case (state_q)
      ST_IDLE: begin
        if (prev_q == InitV && Data_i == InitNextV) begin
          state_d   = ST_COUNT;
          push_req  = 1'b1;
          push_code = EV_START;
        end
      end
      ST_COUNT: begin
        if (Data_i == expected) begin
          if (Data_i == LimitV) begin
            state_d   = ST_SAT;
            push_req  = 1'b1;
            push_code = EV_SAT;
          end
        end else if (Data_i == InitV) begin
          state_d   = ST_IDLE;
          push_req  = 1'b1;
          push_code = EV_RESTART;
        end else begin
          state_d   = ST_FAIL;
          push_req  = 1'b1;
          push_code = EV_ERROR;
          error_d   = 1'b1;
        end
      end
      ST_SAT: begin
        if (Data_i == LimitV) begin
          state_d = ST_SAT;
        end else if (Data_i == InitV) begin
          state_d   = ST_IDLE;
          push_req  = 1'b1;
          push_code = EV_RESTART;
        end else begin
          state_d   = ST_FAIL;
          push_req  = 1'b1;
          push_code = EV_ERROR;
          error_d   = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_FAIL;
      end
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= ST_IDLE;
      prev_q  <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= Data_i;
      error_q <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO. Handshake: an entry transfers on a rising edge where
  // Event_valid_o && Event_ready_i; valid never depends on ready, and the head
  // stays stable until it transfers. A pop frees a slot for a same-edge push.
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FullCnt);
  assign do_pop     = !fifo_empty && Event_ready_i;
  assign do_push    = push_req && (!fifo_full || do_pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i && do_push) begin
      mem_code_q[wr_ptr_q] <= push_code;
      mem_data_q[wr_ptr_q] <= Data_i;
    end
  end

  assign Event_valid_o = !fifo_empty;
  assign Event_code_o  = fifo_empty ? 2'd0  : mem_code_q[rd_ptr_q];
  assign Event_data_o  = fifo_empty ? 32'd0 : mem_data_q[rd_ptr_q];
  assign State_o       = state_q;
  assign Error_o       = error_q;
  assign Overflow_o    = overflow_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: a reference model of the monitor rules fills an
// expected-event queue that is compared against each delivered FIFO head.
module tb_counter_monitor;

  localparam int unsigned INIT  = 8;
  localparam int unsigned LIMIT = 64;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        Reset_i;
  logic [31:0] Data_i;
  logic        Event_ready_i;
  logic        Event_valid_o;
  logic [1:0]  Event_code_o;
  logic [31:0] Event_data_o;
  logic [1:0]  State_o;
  logic        Error_o;
  logic        Overflow_o;

  counter_monitor #(
    .Init (INIT),
    .Limit(LIMIT),
    .Depth(DEPTH)
  ) dut (
    .Clk_i        (clk),
    .Reset_i      (Reset_i),
    .Data_i       (Data_i),
    .Event_ready_i(Event_ready_i),
    .Event_valid_o(Event_valid_o),
    .Event_code_o (Event_code_o),
    .Event_data_o (Event_data_o),
    .State_o      (State_o),
    .Error_o      (Error_o),
    .Overflow_o   (Overflow_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [33:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [1:0]  m_state;
  logic [31:0] m_prev;
  logic        m_err;
  logic        m_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset_i       = 1'b1;
    Data_i        = 32'($urandom_range(0, 100));
    Event_ready_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    check_eq("rst_state", State_o, 0);
    check_eq("rst_valid", Event_valid_o, 0);
    check_eq("rst_code", Event_code_o, 0);
    check_eq("rst_data", Event_data_o, 0);
    check_eq("rst_error", Error_o, 0);
    check_eq("rst_ovf", Overflow_o, 0);
    exp_q.delete();
    m_state = 2'd0;
    m_prev  = 32'd0;
    m_err   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // One clock: compare the head against the scoreboard, apply the model, step.
  task automatic cycle(input logic [31:0] d, input logic rdy);
    logic [33:0] head;
    logic [1:0]  nst;
    logic [1:0]  code_m;
    bit          push_m;
    @(negedge clk);
    Reset_i       = 1'b0;
    Data_i        = d;
    Event_ready_i = rdy;
    check_eq("valid", Event_valid_o, (exp_q.size() != 0));
    if (exp_q.size() != 0 && rdy) begin
      head = exp_q.pop_front();
      pops++;
      check_eq("ev_code", Event_code_o, head[33:32]);
      check_eq("ev_data", Event_data_o, head[31:0]);
    end
    nst    = m_state;
    push_m = 0;
    code_m = 2'd0;
    case (m_state)
      2'd0: if (m_prev == INIT && d == INIT + 1) begin
        nst = 2'd1; push_m = 1; code_m = 2'd0;
      end
      2'd1: begin
        if (d == m_prev + 32'd1) begin
          if (d == LIMIT) begin nst = 2'd2; push_m = 1; code_m = 2'd1; end
        end else if (d == INIT) begin
          nst = 2'd0; push_m = 1; code_m = 2'd3;
        end else begin
          nst = 2'd3; push_m = 1; code_m = 2'd2; m_err = 1'b1;
        end
      end
      2'd2: begin
        if (d == LIMIT) nst = 2'd2;
        else if (d == INIT) begin nst = 2'd0; push_m = 1; code_m = 2'd3; end
        else begin nst = 2'd3; push_m = 1; code_m = 2'd2; m_err = 1'b1; end
      end
      default: nst = 2'd3;
    endcase
    m_prev  = d;
    m_state = nst;
    if (push_m) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({code_m, d});
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("state", State_o, m_state);
    check_eq("error", Error_o, m_err);
    check_eq("overflow", Overflow_o, m_ovf);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(m_prev, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_i       = 1'b1;
    Data_i        = 32'd0;
    Event_ready_i = 1'b0;
    m_state = 2'd0; m_prev = 32'd0; m_err = 1'b0; m_ovf = 1'b0;

    // start, count to limit, hold
    do_reset();
    cycle(8, 1); cycle(8, 1);
    cycle(9, 1);
    check_eq("start_state", State_o, 1);
    for (int v = 10; v <= 64; v++) cycle(32'(v), 1);
    check_eq("sat_state", State_o, 2);
    for (int i = 0; i < 3; i++) cycle(64, 1);
    check_eq("sat_noerr", Error_o, 0);

    // restart from saturation, then a gap in the count
    cycle(8, 1);
    check_eq("restart_state", State_o, 0);
    cycle(9, 1);
    check_eq("restart_start", State_o, 1);
    for (int v = 10; v <= 20; v++) cycle(32'(v), 1);
    cycle(22, 1);
    check_eq("fail_state", State_o, 3);
    check_eq("fail_error", Error_o, 1);
    cycle(8, 1); cycle(9, 1); cycle(8, 1);
    check_eq("fail_absorb", State_o, 3);
    drain(3);

    // overflow: five events with the consumer stalled
    do_reset();
    cycle(8, 0);
    cycle(9, 0); cycle(8, 0); cycle(9, 0); cycle(8, 0); cycle(9, 0);
    check_eq("ovf_set", Overflow_o, 1);
    pops = 0;
    for (int v = 10; v <= 15; v++) cycle(32'(v), 1);
    check_eq("ovf_drained", pops, 4);

    // full FIFO, push and pop on the same edge
    do_reset();
    cycle(8, 0);
    cycle(9, 0); cycle(8, 0); cycle(9, 0); cycle(8, 0);
    cycle(9, 1);
    check_eq("full_pp_ovf", Overflow_o, 0);
    check_eq("full_pp_valid", Event_valid_o, 1);
    pops = 0;
    for (int v = 10; v <= 15; v++) cycle(32'(v), 1);
    check_eq("full_pp_count", pops, 4);

    // reset in the middle of a count with two entries queued
    do_reset();
    cycle(8, 0); cycle(9, 0); cycle(8, 0); cycle(9, 0);
    cycle(10, 1);
    cycle(11, 0);
    do_reset();
    cycle(12, 0);
    check_eq("midrst_valid", Event_valid_o, 0);

    // random consumer during a full run, then random data
    do_reset();
    cycle(8, 1); cycle(8, 1);
    for (int v = 9; v <= 64; v++) cycle(32'(v), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) cycle(64, 1'($urandom_range(0, 1)));
    cycle(8, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) cycle(32'($urandom_range(7, 11)), 1'($urandom_range(0, 1)));
    drain(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
